// File: rtl/vec_seq_pkg.sv
// vec_seq_pkg: shared types and function codes for the vector-op sequencer
package vec_seq_pkg;
    localparam logic [3:0] FN_L2  = 4'b1000;
    localparam logic [3:0] FN_L3  = 4'b1010;
    localparam logic [3:0] FN_L4  = 4'b1011;
    localparam logic [3:0] FN_IP2 = 4'b1100;
    localparam logic [3:0] FN_IP3 = 4'b1110;
    localparam logic [3:0] FN_IP4 = 4'b1111;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    typedef enum logic {UNIT_LEN = 1'b0, UNIT_IP = 1'b1} unit_t;
    typedef logic [3:0] lane_mask_t;
endpackage

// File: rtl/vec_func_decode.sv
// vec_func_decode: function code to legality, unit select and lane mask
module vec_func_decode
    import vec_seq_pkg::*;
(
    input  logic [3:0] func,
    output logic       legal,
    output unit_t      unit_sel,
    output lane_mask_t lane_mask
);
    // bit 2 picks the unit, bits 1:0 pick the dimension (00=2D, 10=3D, 11=4D)
    always_comb begin
        legal     = func inside {FN_L2, FN_L3, FN_L4, FN_IP2, FN_IP3, FN_IP4};
        unit_sel  = func[2] ? UNIT_IP : UNIT_LEN;
        lane_mask = !legal ? 4'b0000 : func[1] ? (func[0] ? 4'b1111 : 4'b0111) : 4'b0011;
    end
endmodule

// File: rtl/vec_op_sequencer.sv
// vec_op_sequencer: one-at-a-time command sequencer for the length and inner-product units
// Optional VEC_SEQ_PERF_EN adds saturating perf_ops/perf_err response counters.
module vec_op_sequencer
    import vec_seq_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 16
)(
    input  logic                clock,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [3:0]          cmd_func,
    input  logic [4*DATA_W-1:0] cmd_a,
    input  logic [4*DATA_W-1:0] cmd_b,
    output logic [4*DATA_W-1:0] op_a,
    output logic [4*DATA_W-1:0] op_b,
    output logic                begin_l,
    output logic                begin_ip,
    input  logic                len_done,
    input  logic [DATA_W-1:0]   len_result,
    input  logic                ip_done,
    input  logic [DATA_W-1:0]   ip_result,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_data,
    output logic                rsp_err,
    output logic                busy
`ifdef VEC_SEQ_PERF_EN
    ,
    output logic [15:0]         perf_ops,
    output logic [15:0]         perf_err
`endif
);
    state_t              state, state_nx;
    unit_t               sel, unit_sel;
    lane_mask_t          lane_mask;
    logic                legal, sel_done, timeout, accept, rsp_fire;
    logic [TO_W-1:0]     to_cnt;
    logic [DATA_W-1:0]   sel_result;
    logic [4*DATA_W-1:0] a_m, b_m;

    vec_func_decode u_dec (
        .func      (cmd_func),
        .legal     (legal),
        .unit_sel  (unit_sel),
        .lane_mask (lane_mask)
    );

    always_comb begin
        a_m = '0;
        b_m = '0;
        for (int i = 0; i < 4; i++) begin
            a_m[i*DATA_W +: DATA_W] = lane_mask[i] ? cmd_a[i*DATA_W +: DATA_W] : '0;
            b_m[i*DATA_W +: DATA_W] = (lane_mask[i] && unit_sel == UNIT_IP) ? cmd_b[i*DATA_W +: DATA_W] : '0;
        end
    end

    assign accept     = cmd_valid && cmd_ready;
    assign rsp_fire   = rsp_valid && rsp_ready;
    assign sel_done   = (sel == UNIT_IP) ? ip_done : len_done;
    assign sel_result = (sel == UNIT_IP) ? ip_result : len_result;
    // a done in the final WAIT cycle beats the timeout
    assign timeout    = !sel_done && (to_cnt + TO_W'(1) == TO_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clock)
        state <= reset ? IDLE : state_nx;

    always_comb
        state_nx = (state == IDLE)  ? (accept ? (legal ? ISSUE : RESP) : IDLE) :
                   (state == ISSUE) ? WAIT :
                   (state == WAIT)  ? ((sel_done || timeout) ? RESP : WAIT) :
                                      (rsp_fire ? IDLE : RESP);

    always_comb begin
        cmd_ready = state == IDLE;
        busy      = state != IDLE;
        rsp_valid = state == RESP;
        begin_l   = state == ISSUE && sel == UNIT_LEN;
        begin_ip  = state == ISSUE && sel == UNIT_IP;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            op_a     <= '0;
            op_b     <= '0;
            sel      <= UNIT_LEN;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
            to_cnt   <= '0;
        end else begin
            if (accept) begin
                op_a     <= a_m;
                op_b     <= b_m;
                sel      <= unit_sel;
                rsp_data <= '0;
                rsp_err  <= !legal;
            end
            if (state == ISSUE)
                to_cnt <= '0;
            if (state == WAIT) begin
                if (sel_done) begin
                    rsp_data <= sel_result;
                    rsp_err  <= 1'b0;
                end else begin
                    to_cnt <= to_cnt + TO_W'(1);
                    if (timeout) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                    end
                end
            end
            if (rsp_fire) begin
                op_a     <= '0;
                op_b     <= '0;
                rsp_data <= '0;
                rsp_err  <= 1'b0;
            end
        end
    end

`ifdef VEC_SEQ_PERF_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_ops <= '0;
            perf_err <= '0;
        end else if (rsp_fire) begin
            if (rsp_err && !(&perf_err))
                perf_err <= perf_err + 16'd1;
            else if (!rsp_err && !(&perf_ops))
                perf_ops <= perf_ops + 16'd1;
        end
    end
`endif
endmodule
